// File: rtl/mcb_pkg.sv
// Shared MCB user-port definitions: command opcodes, port limits and the frame
// writer state encoding.
package mcb_pkg;

  localparam logic [2:0] MCB_CMD_WR      = 3'b000;
  localparam logic [2:0] MCB_CMD_RD      = 3'b001;
  localparam logic [2:0] MCB_CMD_WR_AP   = 3'b010;
  localparam logic [2:0] MCB_CMD_RD_AP   = 3'b011;
  localparam logic [2:0] MCB_CMD_REFRESH = 3'b100;

  localparam int MCB_MAX_BL     = 64;
  localparam int MCB_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CMD  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/mcb_frame_writer.sv
// Streams pixel words into an MCB write FIFO and issues one write command per burst.
// Optional MCB_FRAME_WRITER_STATS_EN adds saturating burst and stall counters.
module mcb_frame_writer
  import mcb_pkg::*;
#(
  parameter int BURST_LEN   = 32,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              calib_done,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              pix_valid,
  input  logic [31:0]       pix_data,
  output logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              wr_err,
  output logic              mcb_cmd_en,
  output logic [2:0]        mcb_cmd_instr,
  output logic [5:0]        mcb_cmd_bl,
  output logic [ADDR_W-1:0] mcb_cmd_byte_addr,
  input  logic              mcb_cmd_full,
  output logic              mcb_wr_en,
  output logic [31:0]       mcb_wr_data,
  output logic [3:0]        mcb_wr_mask,
  input  logic              mcb_wr_full,
  input  logic              mcb_wr_error,
  input  logic              mcb_wr_underrun,
  output logic [1:0]        dbg_state
`ifdef MCB_FRAME_WRITER_STATS_EN
  ,
  output logic [23:0]       stat_bursts,
  output logic [23:0]       stat_stall
`endif
);

  // Pixel handshake: a word transfers on a clk edge where pix_valid && pix_ready;
  // the same cycle it is pushed to the write FIFO (mcb_wr_en). Command strobes
  // only when the command FIFO is not full.

  localparam int FCW_RAW = $clog2(FRAME_WORDS + 1);
  localparam int FCW     = (FCW_RAW > 7) ? FCW_RAW : 7;
  localparam logic [FCW-1:0] FRAME_WORDS_L = FCW'(FRAME_WORDS);
  localparam logic [6:0]     BURST_LEN_L   = 7'(BURST_LEN);

  wr_state_t         r_state;
  wr_state_t         w_next_state;
  logic [6:0]        r_burst_cnt;
  logic [FCW-1:0]    r_frame_cnt;
  logic [ADDR_W-1:0] r_burst_addr;
  logic              r_frame_done;
  logic              r_wr_err;

  logic [FCW-1:0]    w_frame_fill;
  logic [FCW-1:0]    w_fill_inc;
  logic [6:0]        w_cnt_inc;
  logic              w_pix_ready;
  logic              w_accept;
  logic              w_cmd_en;
  logic              w_frame_end;
  logic              w_start;
  logic              w_unused;

  assign w_unused = ^base_addr[1:0];

  assign w_start      = frame_start && calib_done;
  assign w_frame_fill = r_frame_cnt + FCW'(r_burst_cnt);
  assign w_pix_ready  = (r_state == FILL) && calib_done && !mcb_wr_full &&
                        (r_burst_cnt < BURST_LEN_L) && (w_frame_fill < FRAME_WORDS_L);
  assign w_accept     = pix_valid && w_pix_ready;
  assign w_cnt_inc    = r_burst_cnt + 7'(w_accept);
  assign w_fill_inc   = w_frame_fill + FCW'(w_accept);
  assign w_cmd_en     = (r_state == CMD) && !mcb_cmd_full;
  assign w_frame_end  = (w_frame_fill == FRAME_WORDS_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_start) w_next_state = FILL;
      // A flush that coincides with an accept still closes the burst with that word.
      FILL: if ((w_cnt_inc == BURST_LEN_L) || (w_fill_inc == FRAME_WORDS_L) ||
                (flush && (w_cnt_inc != 7'd0)))
              w_next_state = CMD;
      CMD:  if (w_cmd_en) w_next_state = w_frame_end ? IDLE : FILL;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_cnt  <= '0;
      r_frame_cnt  <= '0;
      r_burst_addr <= '0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_wr_err     <= r_wr_err | mcb_wr_error | mcb_wr_underrun;
      case (r_state)
        IDLE: if (w_start) begin
          r_burst_addr <= {base_addr[ADDR_W-1:2], 2'b00};
          r_frame_cnt  <= '0;
          r_burst_cnt  <= '0;
        end
        FILL: if (w_accept) r_burst_cnt <= w_cnt_inc;
        CMD: if (w_cmd_en) begin
          // Words are 4 bytes; address wraps naturally at ADDR_W bits.
          r_burst_addr <= r_burst_addr + ADDR_W'({r_burst_cnt, 2'b00});
          r_frame_cnt  <= w_frame_fill;
          r_burst_cnt  <= '0;
          r_frame_done <= w_frame_end;
        end
        default: ;
      endcase
    end
  end

  assign pix_ready         = w_pix_ready;
  assign busy              = (r_state != IDLE);
  assign frame_done        = r_frame_done;
  assign wr_err            = r_wr_err;
  assign mcb_cmd_en        = w_cmd_en;
  assign mcb_cmd_instr     = MCB_CMD_WR;
  assign mcb_cmd_bl        = (r_state == CMD) ? 6'(r_burst_cnt - 7'd1) : 6'd0;
  assign mcb_cmd_byte_addr = (r_state == CMD) ? r_burst_addr : '0;
  assign mcb_wr_en         = w_accept;
  assign mcb_wr_data       = w_accept ? pix_data : 32'd0;
  assign mcb_wr_mask       = 4'b0000;
  assign dbg_state         = r_state;

`ifdef MCB_FRAME_WRITER_STATS_EN
  logic [23:0] r_stat_bursts;
  logic [23:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (r_state != IDLE) && pix_valid && !w_pix_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_bursts <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_cmd_en && (r_stat_bursts != 24'hFFFFFF)) r_stat_bursts <= r_stat_bursts + 24'd1;
      if (w_stall && (r_stat_stall != 24'hFFFFFF))   r_stat_stall  <= r_stat_stall + 24'd1;
    end
  end

  assign stat_bursts = r_stat_bursts;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_mcb_frame_writer.sv
// Self-checking bench for mcb_frame_writer (BURST_LEN 32, FRAME_WORDS 72) with
// data and command scoreboards fed by the stimulus tasks.
module tb_mcb_frame_writer;

  localparam int BL = 32;
  localparam int FW = 72;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          calib_done = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          flush = 1'b0;
  logic          pix_valid = 1'b0;
  logic [31:0]   pix_data = '0;
  logic          pix_ready, busy, frame_done, wr_err;
  logic          mcb_cmd_en;
  logic [2:0]    mcb_cmd_instr;
  logic [5:0]    mcb_cmd_bl;
  logic [AW-1:0] mcb_cmd_byte_addr;
  logic          mcb_cmd_full = 1'b0;
  logic          mcb_wr_en;
  logic [31:0]   mcb_wr_data;
  logic [3:0]    mcb_wr_mask;
  logic          mcb_wr_full = 1'b0;
  logic          mcb_wr_error = 1'b0;
  logic          mcb_wr_underrun = 1'b0;
  logic [1:0]    dbg_state;
`ifdef MCB_FRAME_WRITER_STATS_EN
  logic [23:0]   stat_bursts, stat_stall;
`endif

  mcb_frame_writer #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done), .frame_start(frame_start),
    .base_addr(base_addr), .flush(flush), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done), .wr_err(wr_err),
    .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr), .mcb_cmd_bl(mcb_cmd_bl),
    .mcb_cmd_byte_addr(mcb_cmd_byte_addr), .mcb_cmd_full(mcb_cmd_full),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_data(mcb_wr_data), .mcb_wr_mask(mcb_wr_mask),
    .mcb_wr_full(mcb_wr_full), .mcb_wr_error(mcb_wr_error),
    .mcb_wr_underrun(mcb_wr_underrun), .dbg_state(dbg_state)
`ifdef MCB_FRAME_WRITER_STATS_EN
    , .stat_bursts(stat_bursts), .stat_stall(stat_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Command entry: {last_of_frame, bl[5:0], byte_addr[29:0]}
  logic [31:0] exp_data_q[$];
  logic [36:0] exp_cmd_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int cmd_cnt = 0;
  int fd_cnt = 0;
  int exp_fd_cyc = -1;
  logic tog_on = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    cyc = cyc + 1;
    if (mcb_wr_en) begin
      wr_cnt++;
      check_eq("wr_while_full", mcb_wr_full, 0);
      check_eq("wr_mask", mcb_wr_mask, 0);
      if (exp_data_q.size() == 0) check_eq("wr_extra", 1, 0);
      else check_eq("wr_data", mcb_wr_data, exp_data_q.pop_front());
    end
    if (mcb_cmd_en) begin
      cmd_cnt++;
      if (exp_cmd_q.size() == 0) check_eq("cmd_extra", 1, 0);
      else begin
        e = exp_cmd_q.pop_front();
        check_eq("cmd_bl", mcb_cmd_bl, e[35:30]);
        check_eq("cmd_addr", mcb_cmd_byte_addr, e[29:0]);
        check_eq("cmd_instr", mcb_cmd_instr, 0);
        if (e[36]) exp_fd_cyc = cyc + 1;
      end
    end
    if (frame_done || (cyc == exp_fd_cyc)) begin
      if (frame_done) fd_cnt++;
      check_eq("frame_done_cyc", frame_done, cyc == exp_fd_cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic push_cmd(input logic last, input logic [5:0] bl, input logic [AW-1:0] addr);
    exp_cmd_q.push_back({last, bl, addr});
  endtask

  task automatic send_words(input int n);
    logic acc;
    int   t;
    for (int i = 0; i < n; i++) begin
      pix_data  = $urandom;
      pix_valid = 1'b1;
      exp_data_q.push_back(pix_data);
      t = 0;
      do begin
        @(negedge clk);
        acc = pix_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      if (!acc) check_eq("accept_timeout", 0, 1);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_cmds(input int target);
    int t = 0;
    while (cmd_cnt < target && t < 200) begin
      tick(1);
      t++;
    end
    check_eq("cmd_wait", cmd_cnt, target);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tick(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pix_ready", pix_ready, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_wr_err", wr_err, 0);
    check_eq("rst_cmd_en", mcb_cmd_en, 0);
    check_eq("rst_cmd_bl", mcb_cmd_bl, 0);
    check_eq("rst_cmd_addr", mcb_cmd_byte_addr, 0);
    check_eq("rst_wr_en", mcb_wr_en, 0);
    check_eq("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    tick(2);

    // frame_start without calibration is dropped
    calib_done = 1'b0;
    pulse_start(30'h500);
    tick(2);
    check_eq("start_no_calib", busy, 0);
    calib_done = 1'b1;

    // Frame A: two full bursts then an 8-word frame tail
    push_cmd(1'b0, 6'd31, 30'h100);
    push_cmd(1'b0, 6'd31, 30'h180);
    push_cmd(1'b1, 6'd7,  30'h200);
    pulse_start(30'h100);
    check_eq("busy_after_start", busy, 1);
    send_words(64);
    send_words(8);
    wait_cmds(3);
    tick(3);
    check_eq("frame_a_done_cnt", fd_cnt, 1);
    pix_valid = 1'b1;
    tick(1);
    check_eq("ready_after_frame", pix_ready, 0);
    check_eq("busy_after_frame", busy, 0);
    pix_valid = 1'b0;
    check_eq("frame_a_words", wr_cnt, 72);

    // Frame B: unaligned base, flush after 5 words
    push_cmd(1'b0, 6'd4, 30'h2000);
    pulse_start(30'h2003);
    send_words(5);
    pulse_flush();
    wait_cmds(4);
    tick(2);
    pulse_flush();
    pulse_start(30'h9000);

    // wr_full toggling every cycle during a full burst
    push_cmd(1'b0, 6'd31, 30'h2014);
    tog_on = 1'b1;
    fork
      begin
        send_words(32);
        tog_on = 1'b0;
      end
      begin
        while (tog_on) begin
          mcb_wr_full = ~mcb_wr_full;
          tick(1);
        end
        mcb_wr_full = 1'b0;
      end
    join
    wait_cmds(5);

    // cmd FIFO full for 10 cycles in CMD
    push_cmd(1'b0, 6'd31, 30'h2094);
    mcb_cmd_full = 1'b1;
    send_words(32);
    pix_valid = 1'b1;
    pix_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      check_eq("cmd_held", mcb_cmd_en, 0);
      check_eq("ready_in_cmd", pix_ready, 0);
      tick(1);
    end
    mcb_cmd_full = 1'b0;
    pix_valid = 1'b0;
    tick(1);
    check_eq("cmd_single", cmd_cnt, 6);
    tick(3);
    check_eq("cmd_no_repeat", cmd_cnt, 6);

    push_cmd(1'b1, 6'd2, 30'h2114);
    send_words(3);
    wait_cmds(7);
    tick(3);
    check_eq("frame_b_done_cnt", fd_cnt, 2);

    // Frame C: sticky error, then reset mid-burst
    pulse_start(30'h3000);
    send_words(10);
    mcb_wr_underrun = 1'b1;
    tick(1);
    mcb_wr_underrun = 1'b0;
    tick(2);
    check_eq("wr_err_sticky", wr_err, 1);
    pix_valid = 1'b1;
    pix_data  = 32'h1234_5678;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_pix_ready", pix_ready, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_wr_en", mcb_wr_en, 0);
    check_eq("arst_wr_err", wr_err, 0);
    check_eq("arst_state", dbg_state, 0);
    tick(3);
    pix_valid = 1'b0;
    reset_n = 1'b1;
    tick(2);
    check_eq("no_cmd_after_reset", cmd_cnt, 7);

    // Frame D: fresh base, calib drop mid-burst holds state
    push_cmd(1'b0, 6'd31, 30'h4000);
    pulse_start(30'h4000);
    send_words(16);
    calib_done = 1'b0;
    tick(2);
    check_eq("ready_no_calib", pix_ready, 0);
    check_eq("state_held", dbg_state, 1);
    calib_done = 1'b1;
    send_words(16);
    wait_cmds(8);
    tick(3);

    check_eq("data_q_empty", exp_data_q.size(), 0);
    check_eq("cmd_q_empty", exp_cmd_q.size(), 0);
    check_eq("total_words", wr_cnt, 186);
    check_eq("total_frame_done", fd_cnt, 2);
`ifdef MCB_FRAME_WRITER_STATS_EN
    check_eq("stat_bursts", stat_bursts, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
